// File: rtl/ball_pkg.sv
// Shared constants, state encoding and helpers for the ball/brick state owner.
package ball_pkg;

    localparam int unsigned H        = 640;
    localparam int unsigned V        = 480;
    // The paddle row sits 30 px above the bottom of the playfield.
    localparam int unsigned PADDLE_Y = V - 30;
    localparam int unsigned PADDLE_W = 80;
    localparam int unsigned BRICK_W  = 1440;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        MOVE  = 2'd1,
        LOST  = 2'd2,
        OVER  = 2'd3
    } ball_state_e;

    function automatic logic [9:0] sat_inc(input logic [9:0] v, input logic [9:0] cap);
        return (v >= cap) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/ball_state_fsm.sv
// Serve / play / life-lost / game-over sequencer; emits load strobes for the
// ball datapath registers held in ball_state.
//
//   state | meaning
//   SERVE | ball rides the paddle, waits for launch on a frame tick
//   MOVE  | each frame tick latches the ball_control step results
//   LOST  | one-cycle bookkeeping after a miss (lives decrement)
//   OVER  | game finished, everything held until launch + frame tick
module ball_state_fsm
    import ball_pkg::*;
#(
    parameter int unsigned LIVES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_frame_tick,
    input  logic        i_launch,
    input  logic        i_loss,
    input  logic        i_cleared,
    output ball_state_e o_state,
    output logic [1:0]  o_lives,
    output logic        o_win,
    output logic        o_step_done,
    output logic        o_serve_pos,
    output logic        o_launch_ld,
    output logic        o_move_ld,
    output logic        o_vel_clr,
    output logic        o_restart
);

    localparam logic [1:0] C_LIVES = 2'(LIVES);

    ball_state_e r_state;
    ball_state_e w_state_nxt;
    logic [1:0]  r_lives;
    logic [1:0]  w_lives_nxt;
    logic        r_win;
    logic        w_win_nxt;
    logic        r_step_done;
    logic        w_step_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= SERVE;
            r_lives     <= C_LIVES;
            r_win       <= 1'b0;
            r_step_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lives     <= w_lives_nxt;
            r_win       <= w_win_nxt;
            r_step_done <= w_step_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lives_nxt = r_lives;
        w_win_nxt   = r_win;
        w_step_nxt  = 1'b0;
        o_serve_pos = 1'b0;
        o_launch_ld = 1'b0;
        o_move_ld   = 1'b0;
        o_vel_clr   = 1'b0;
        o_restart   = 1'b0;

        case (r_state)
            SERVE: begin
                if (i_frame_tick) begin
                    o_serve_pos = 1'b1;
                    w_step_nxt  = 1'b1;
                    if (i_launch) begin
                        o_launch_ld = 1'b1;
                        w_state_nxt = MOVE;
                    end
                end
            end
            MOVE: begin
                if (i_frame_tick) begin
                    o_move_ld  = 1'b1;
                    w_step_nxt = 1'b1;
                    // A miss outranks clearing the last brick on the same step.
                    if (i_loss) begin
                        w_state_nxt = LOST;
                    end else if (i_cleared) begin
                        w_state_nxt = OVER;
                        w_win_nxt   = 1'b1;
                    end
                end
            end
            LOST: begin
                if (r_lives == 2'd1) begin
                    w_lives_nxt = 2'd0;
                    w_win_nxt   = 1'b0;
                    w_state_nxt = OVER;
                end else begin
                    w_lives_nxt = r_lives - 2'd1;
                    o_vel_clr   = 1'b1;
                    w_state_nxt = SERVE;
                end
            end
            OVER: begin
                if (i_frame_tick && i_launch) begin
                    o_restart   = 1'b1;
                    o_serve_pos = 1'b1;
                    w_lives_nxt = C_LIVES;
                    w_win_nxt   = 1'b0;
                    w_state_nxt = SERVE;
                end
            end
            default: begin
                w_state_nxt = SERVE;
            end
        endcase
    end

    assign o_state     = r_state;
    assign o_lives     = r_lives;
    assign o_win       = r_win;
    assign o_step_done = r_step_done;

endmodule

// File: rtl/ball_state.sv
// Registered ball position/velocity/direction and brick map, updated once per
// frame from ball_control's next_* results. Optional BALL_SPEEDUP_EN adds a
// periodic velocity bump during play.
module ball_state
   import ball_pkg::*;
#(
   parameter int unsigned INIT_VX        = 2,
   parameter int unsigned INIT_VY        = 3,
   parameter int unsigned LIVES          = 3,
   parameter int unsigned SPEEDUP_FRAMES = 600,
   parameter int unsigned MAX_V          = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_tick,
   input  logic               launch,
   input  logic [9:0]         paddle_x,
   input  logic [BRICK_W-1:0] next_bricks,
   input  logic [9:0]         next_ball_x,
   input  logic [9:0]         next_ball_y,
   input  logic [9:0]         next_ball_vx,
   input  logic [9:0]         next_ball_vy,
   input  logic [1:0]         next_ball_dir,
   output logic [BRICK_W-1:0] bricks,
   output logic [9:0]         ball_x,
   output logic [9:0]         ball_y,
   output logic [9:0]         ball_vx,
   output logic [9:0]         ball_vy,
   output logic [1:0]         ball_dir,
   output logic [1:0]         lives,
   output logic [1:0]         state,
   output logic               step_done,
   output logic               game_over,
   output logic               win
);

   localparam logic [10:0] C_H11       = 11'(H);
   localparam logic [9:0]  C_X_RST     = 10'(H / 2);
   localparam logic [9:0]  C_Y_SERVE   = 10'(PADDLE_Y - 1);
   localparam logic [9:0]  C_PADDLE_Y  = 10'(PADDLE_Y);
   localparam logic [10:0] C_PW11      = 11'(PADDLE_W);
   localparam logic [10:0] C_HALF_PW11 = 11'(PADDLE_W / 2);
   localparam logic [9:0]  C_INIT_VX   = 10'(INIT_VX);
   localparam logic [9:0]  C_INIT_VY   = 10'(INIT_VY);
   localparam logic [1:0]  C_DIR_RST   = 2'b10;

   logic [BRICK_W-1:0] r_bricks;
   logic [9:0]         r_ball_x;
   logic [9:0]         r_ball_y;
   logic [9:0]         r_ball_vx;
   logic [9:0]         r_ball_vy;
   logic [1:0]         r_ball_dir;

   ball_state_e w_state;
   logic [1:0]  w_lives;
   logic        w_win;
   logic        w_step_done;
   logic        w_serve_pos;
   logic        w_launch_ld;
   logic        w_move_ld;
   logic        w_vel_clr;
   logic        w_restart;

   logic [10:0] w_paddle11;
   logic [10:0] w_next_x11;
   logic [10:0] w_serve_sum;
   logic [9:0]  w_serve_x;
   logic        w_in_zone;
   logic        w_loss;
   logic        w_cleared;
   logic [9:0]  w_vx_ld;
   logic [9:0]  w_vy_ld;

   // Paddle arithmetic is carried in 11 bits so paddle_x near 1023 cannot wrap.
   assign w_paddle11  = {1'b0, paddle_x};
   assign w_next_x11  = {1'b0, next_ball_x};
   assign w_serve_sum = w_paddle11 + C_HALF_PW11;
   assign w_serve_x   = (w_serve_sum > C_H11) ? C_H11[9:0] : w_serve_sum[9:0];
   assign w_in_zone   = (next_ball_y >= C_PADDLE_Y);
   assign w_loss      = w_in_zone &&
                        ((w_next_x11 < w_paddle11) || (w_next_x11 > (w_paddle11 + C_PW11)));
   assign w_cleared   = (next_bricks == '0);

`ifdef BALL_SPEEDUP_EN
   localparam logic [9:0] C_SPEEDUP = 10'(SPEEDUP_FRAMES);
   localparam logic [9:0] C_MAX_V   = 10'(MAX_V);

   logic [9:0] r_frame_cnt;
   logic [9:0] w_frame_cnt_inc;
   logic       w_speedup_hit;

   assign w_frame_cnt_inc = r_frame_cnt + 10'd1;
   assign w_speedup_hit   = (w_frame_cnt_inc == C_SPEEDUP);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_frame_cnt <= '0;
      end else if (w_move_ld) begin
         r_frame_cnt <= w_speedup_hit ? 10'd0 : w_frame_cnt_inc;
      end else if (w_state != MOVE) begin
         r_frame_cnt <= '0;
      end
   end

   // The bump rides on top of this step's ball_control result.
   assign w_vx_ld = w_speedup_hit ? sat_inc(next_ball_vx, C_MAX_V) : next_ball_vx;
   assign w_vy_ld = w_speedup_hit ? sat_inc(next_ball_vy, C_MAX_V) : next_ball_vy;
`else
   assign w_vx_ld = next_ball_vx;
   assign w_vy_ld = next_ball_vy;
`endif

   ball_state_fsm #(
      .LIVES (LIVES)
   ) u_fsm (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_frame_tick (frame_tick),
      .i_launch     (launch),
      .i_loss       (w_loss),
      .i_cleared    (w_cleared),
      .o_state      (w_state),
      .o_lives      (w_lives),
      .o_win        (w_win),
      .o_step_done  (w_step_done),
      .o_serve_pos  (w_serve_pos),
      .o_launch_ld  (w_launch_ld),
      .o_move_ld    (w_move_ld),
      .o_vel_clr    (w_vel_clr),
      .o_restart    (w_restart)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bricks   <= '1;
         r_ball_x   <= C_X_RST;
         r_ball_y   <= C_Y_SERVE;
         r_ball_vx  <= '0;
         r_ball_vy  <= '0;
         r_ball_dir <= C_DIR_RST;
      end else begin
         if (w_move_ld) begin
            r_bricks   <= next_bricks;
            r_ball_x   <= next_ball_x;
            r_ball_y   <= next_ball_y;
            r_ball_vx  <= w_vx_ld;
            r_ball_vy  <= w_vy_ld;
            r_ball_dir <= next_ball_dir;
         end
         if (w_serve_pos) begin
            r_ball_x <= w_serve_x;
            r_ball_y <= C_Y_SERVE;
         end
         if (w_launch_ld) begin
            r_ball_vx  <= C_INIT_VX;
            r_ball_vy  <= C_INIT_VY;
            r_ball_dir <= C_DIR_RST;
         end
         if (w_vel_clr) begin
            r_ball_vx <= '0;
            r_ball_vy <= '0;
         end
         if (w_restart) begin
            r_bricks   <= '1;
            r_ball_vx  <= '0;
            r_ball_vy  <= '0;
            r_ball_dir <= C_DIR_RST;
         end
      end
   end

   assign bricks    = r_bricks;
   assign ball_x    = r_ball_x;
   assign ball_y    = r_ball_y;
   assign ball_vx   = r_ball_vx;
   assign ball_vy   = r_ball_vy;
   assign ball_dir  = r_ball_dir;
   assign lives     = w_lives;
   assign state     = w_state;
   assign step_done = w_step_done;
   assign game_over = (w_state == OVER);
   assign win       = w_win;

endmodule
